// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_WIDTH = 64;
  localparam int unsigned RF_DEPTH = 16;
  localparam int unsigned RF_NRD   = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear/ready controller: sweeps every entry to zero after reset or on clr_req,
// then holds READY until the next clear request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_we_c,
  output logic [AW-1:0] clr_addr_c
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] cidx, cidx_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_CLEAR;
      cidx  <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cidx  <= cidx_nxt;
      ready <= (state_nxt == RF_READY);
    end
  end

  // Reset keeps hammering entry 0 so the sweep restarts cleanly from a known point.
  always_comb begin
    state_nxt  = state;
    cidx_nxt   = cidx;
    clr_we_c   = 1'b0;
    clr_addr_c = cidx;
    if (reset) begin
      clr_we_c   = 1'b1;
      clr_addr_c = '0;
    end else begin
      unique case (state)
        RF_CLEAR: begin
          clr_we_c = 1'b1;
          cidx_nxt = cidx + AW'(1);
          if (cidx == AW'(DEPTH - 1)) state_nxt = RF_READY;
        end
        RF_READY: begin
          if (clr_req) begin
            state_nxt = RF_CLEAR;
            cidx_nxt  = '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD combinational read ports, two prioritised write ports.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned NRD   = RF_NRD,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [WIDTH-1:0]     wdata1
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we_c;
  logic [AW-1:0]    clr_addr_c;

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .ready      (ready),
    .clr_we_c   (clr_we_c),
    .clr_addr_c (clr_addr_c)
  );

  // Port 1 wins an address collision; user writes only land in READY.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_addr_c] <= '0;
    end else if (ready) begin
      if (we1) mem[waddr1] <= wdata1;
      if (we0 && !(we1 && (waddr0 == waddr1))) mem[waddr0] <= wdata0;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = raddr[k*AW +: AW];

    always_comb begin
      rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (waddr1 == ra))      rv = wdata1;
      else if (we0 && (waddr0 == ra)) rv = wdata0;
`endif
    end

    assign rdata[k*WIDTH +: WIDTH] = (ready && !reset) ? rv : '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 16x64/2 ports plus a 32-deep, 4-port instance).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, clr_req, ready;
  logic [7:0]   raddr;
  logic [127:0] rdata;
  logic         we0, we1;
  logic [3:0]   waddr0, waddr1;
  logic [63:0]  wdata0, wdata1;

  logic         reset4, clr_req4, ready4;
  logic [19:0]  raddr4;
  logic [63:0]  rdata4;
  logic         we0_4, we1_4;
  logic [4:0]   waddr0_4, waddr1_4;
  logic [15:0]  wdata0_4, wdata1_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .ready(ready),
    .raddr(raddr), .rdata(rdata),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(32), .NRD(4)) dut4 (
    .clk(clk), .reset(reset4), .clr_req(clr_req4), .ready(ready4),
    .raddr(raddr4), .rdata(rdata4),
    .we0(we0_4), .waddr0(waddr0_4), .wdata0(wdata0_4),
    .we1(we1_4), .waddr1(waddr1_4), .wdata1(wdata1_4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      raddr = {4'(15 - i), 4'(i)};
      #1;
      check(tag, rdata[63:0], 64'h0);
      check(tag, rdata[127:64], 64'h0);
    end
  endtask

  initial begin
    int r16, r32, rc;
    reset = 1'b1; clr_req = 1'b0; raddr = '0;
    we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    reset4 = 1'b1; clr_req4 = 1'b0; raddr4 = '0;
    we0_4 = 1'b0; we1_4 = 1'b0; waddr0_4 = '0; waddr1_4 = '0; wdata0_4 = '0; wdata1_4 = '0;

    // Reset sweep, with a write to r0 attempted throughout
    tick();
    check("reset_ready", 64'(ready), 64'h0);
    check("reset_ready4", 64'(ready4), 64'h0);
    check("reset_rdata", rdata[63:0], 64'h0);
    reset = 1'b0; reset4 = 1'b0;
    we0 = 1'b1; waddr0 = 4'd0; wdata0 = 64'hAAAA_5555_AAAA_5555;
    r16 = 0; r32 = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready && r16 == 0) begin r16 = c; we0 = 1'b0; end
      if (ready4 && r32 == 0) r32 = c;
      if (!ready) check("sweep_rdata", rdata[63:0], 64'h0);
    end
    we0 = 1'b0;
    check("sweep_len16", 64'(r16), 64'd16);
    check("sweep_len32", 64'(r32), 64'd32);
    check_all_zero("post_reset_zero");

    // Plain write then read on both ports
    we0 = 1'b1; waddr0 = 4'd5; wdata0 = 64'hDEAD_BEEF_0000_0001; raddr = {4'd5, 4'd5};
    #1;
    check("wr_same_cycle", rdata[63:0], BYP ? 64'hDEAD_BEEF_0000_0001 : 64'h0);
    tick(); we0 = 1'b0; #1;
    check("wr_rd_p0", rdata[63:0], 64'hDEAD_BEEF_0000_0001);
    check("wr_rd_p1", rdata[127:64], 64'hDEAD_BEEF_0000_0001);

    // Collision: port 1 wins
    we0 = 1'b1; waddr0 = 4'd3; wdata0 = 64'h11;
    we1 = 1'b1; waddr1 = 4'd3; wdata1 = 64'h22;
    tick(); we0 = 1'b0; we1 = 1'b0; raddr = {4'd3, 4'd3}; #1;
    check("collision_p0", rdata[63:0], 64'h22);
    check("collision_p1", rdata[127:64], 64'h22);

    // Two writes to distinct addresses both commit
    we0 = 1'b1; waddr0 = 4'd8; wdata0 = 64'h88;
    we1 = 1'b1; waddr1 = 4'd9; wdata1 = 64'h99;
    tick(); we0 = 1'b0; we1 = 1'b0; raddr = {4'd9, 4'd8}; #1;
    check("dual_wr_r8", rdata[63:0], 64'h88);
    check("dual_wr_r9", rdata[127:64], 64'h99);

    // Forwarding behaviour on r7
    we0 = 1'b1; waddr0 = 4'd7; wdata0 = 64'h5;
    tick(); we0 = 1'b0;
    we0 = 1'b1; waddr0 = 4'd7; wdata0 = 64'h9; raddr = {4'd5, 4'd7};
    #1;
    check("bypass_p0", rdata[63:0], BYP ? 64'h9 : 64'h5);
    check("bypass_nomatch_p1", rdata[127:64], 64'hDEAD_BEEF_0000_0001);
    tick(); we0 = 1'b0; #1;
    check("bypass_next", rdata[63:0], 64'h9);
    we0 = 1'b1; waddr0 = 4'd7; wdata0 = 64'hA;
    we1 = 1'b1; waddr1 = 4'd7; wdata1 = 64'hB;
    #1;
    check("bypass_prio", rdata[63:0], BYP ? 64'hB : 64'h9);
    tick(); we0 = 1'b0; we1 = 1'b0; #1;
    check("bypass_prio_next", rdata[63:0], 64'hB);

    // 4-port instance: independent addresses
    we0_4 = 1'b1; waddr0_4 = 5'd3;  wdata0_4 = 16'h0303;
    we1_4 = 1'b1; waddr1_4 = 5'd17; wdata1_4 = 16'h1717;
    tick();
    waddr0_4 = 5'd30; wdata0_4 = 16'h3030;
    waddr1_4 = 5'd31; wdata1_4 = 16'h3131;
    tick(); we0_4 = 1'b0; we1_4 = 1'b0;
    raddr4 = {5'd31, 5'd30, 5'd17, 5'd3}; #1;
    check("nrd4_fwd", rdata4, 64'h3131_3030_1717_0303);
    raddr4 = {5'd3, 5'd17, 5'd30, 5'd31}; #1;
    check("nrd4_rev", rdata4, 64'h0303_1717_3030_3131);

    // Clear request interrupted by reset after 5 cycles
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; waddr0 = 4'(i); wdata0 = 64'(i + 1);
      tick();
    end
    we0 = 1'b0; raddr = {4'd15, 4'd0}; #1;
    check("load_r0", rdata[63:0], 64'd1);
    check("load_r15", rdata[127:64], 64'd16);
    clr_req = 1'b1; we1 = 1'b1; waddr1 = 4'd2; wdata1 = 64'hFF;
    tick(); clr_req = 1'b0; we1 = 1'b0;
    check("clr_ready_low", 64'(ready), 64'h0);
    check("clr_rdata_masked", rdata[63:0], 64'h0);
    rc = 0;
    for (int c = 1; c <= 40; c++) begin
      reset = (c == 5);
      tick();
      if (c == 5) check("mid_reset_rdata", rdata[127:64], 64'h0);
      if (ready) begin rc = c; break; end
    end
    reset = 1'b0;
    check("clr_reset_len", 64'(rc), 64'd21);
    check_all_zero("post_clr_zero");

    // clr_req held three cycles acts as a single request
    we0 = 1'b1; waddr0 = 4'd4; wdata0 = 64'h44;
    tick(); we0 = 1'b0;
    rc = 0;
    for (int c = 0; c <= 40; c++) begin
      clr_req = (c < 3);
      tick();
      if (ready) begin rc = c; break; end
    end
    clr_req = 1'b0;
    check("clr_held_len", 64'(rc), 64'd16);
    raddr = {4'd4, 4'd4}; #1;
    check("clr_held_r4", rdata[63:0], 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the fixed 16×64 two-read/one-write register file in the pipeline decode stage. It provides NRD combinational read ports and two write ports with fixed priority. A sequential clear engine zeroes one entry per cycle after reset or on request, and a `ready` flag tells the pipeline when the file is usable. An optional write-to-read bypass gives same-cycle forwarding.

## Interface
Parameters:
- WIDTH, 64: data width per entry.
- DEPTH, 16: number of entries, power of two, minimum 2.
- NRD, 2: number of read ports, 1–4.
- AW, $clog2(DEPTH): address width, derived; never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- clr_req  in  1  single-cycle pulse requesting a full clear.
- ready  out  1  high when the file is in READY; reset value 0.
- raddr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  out  NRD*WIDTH  read data; port k is bits [k*WIDTH +: WIDTH]. Value is 0 while reset is asserted.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1, which has priority over port 0.
- waddr1  in  AW  write address, port 1.
- wdata1  in  WIDTH  write data, port 1.

## Operation
The controller has two states, CLEAR and READY, and a clear index `cidx` of AW bits.

- **reset:** next state is CLEAR, `cidx` = 0. Entry 0 is written to 0 on every edge while reset is held.
- **CLEAR:**
  - Each edge writes `mem[cidx]` = 0 and increments `cidx`.
  - When `cidx` = DEPTH-1 is cleared, the next state is READY and `cidx` wraps to 0.
  - we0, we1 and clr_req are ignored.
  - Every rdata port is forced to 0.
- **READY:**
  - we0/we1 commit on the edge.
  - If both are set with waddr0 == waddr1, only wdata1 is stored.
  - If clr_req = 1, the next state is CLEAR. Writes presented in the same cycle still commit and are then cleared by the sweep.
- **Reads:** combinational. `rdata[k]` = `mem[raddr[k]]` when in READY; otherwise 0.
- **ready:** registered; equals (state == READY).
- No arithmetic beyond `cidx` + 1, which is AW bits and wraps naturally.

## Timing
- Read latency: 0 cycles (combinational from raddr and memory).
- Write latency: data is visible on reads in the cycle after the write edge (without bypass).
- Clear duration: exactly DEPTH cycles from the first edge with reset = 0 (or the edge that samples clr_req) to the edge at which `ready` rises.
- Reset mid-clear: restarts the sweep at `cidx` = 0.
- clr_req held for more than one cycle: behaves like a single pulse while in CLEAR. If it is still high in READY, it starts a new sweep.
- Reset dominates clr_req and writes.

## Configuration
- **REGFILE_BYPASS_EN defined:** in READY, if `raddr[k]` matches an enabled write address in the same cycle, `rdata[k]` returns that write data, with port 1 taking priority over port 0. Rdata therefore depends combinationally on we/waddr/wdata.
- **Not defined:** reads return stored contents only; same-cycle writes are not visible until the next cycle.
- The CLEAR masking applies in both builds.

## Structure
- **Package `regfile_pkg`:** state enum `rf_state_t` {RF_CLEAR, RF_READY} and the default WIDTH/DEPTH/NRD constants.
- **Sub-module `regfile_clear_seq`:** state register, `cidx` counter and `ready`. It exports a clear-write strobe and address to the array.
- **Top level:** the storage array, write-priority mux, generate loop over read ports and bypass logic stay here.

## Test plan
- **Reset sweep:** reset for 1 cycle → ready = 0 for 16 cycles and rises on the 16th edge. All 16 entries then read 0, and rdata = 0 throughout the sweep even with writes attempted.
- **Write/read:** write 0xDEAD_BEEF_0000_0001 to r5 via port 0; next cycle read r5 on both read ports → that value.
- **Write collision:** we0 = we1 = 1, both to r3, wdata0 = 0x11, wdata1 = 0x22 → r3 reads 0x22.
- **Clear request:**
  - Setup: load r0–r15 with value i+1.
  - Stimulus: pulse clr_req, then reset after 5 cycles.
  - Response: ready is low for 5 + 16 cycles, and all entries read 0 afterwards.
- **Bypass (with REGFILE_BYPASS_EN):** r7 holds 0x5; write 0x9 to r7 while raddr0 = 7 → rdata0 = 0x9 in the same cycle. Without the macro → 0x5, then 0x9 the following cycle.
- **NRD = 4, DEPTH = 32:** sweep takes 32 cycles; four distinct addresses read independently and correctly.
